// File: rtl/hilo_multu_unit.sv
// hilo_multu_unit: 32-iteration shift-add unsigned multiplier that owns the
// architectural HI/LO registers. MULTU starts a multiply. MFHI/MFLO and a second
// MULTU are held off with stall while a product is still in flight.
module hilo_multu_unit #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  MULTU = 6'b011001,
    parameter logic [5:0]  MFHI  = 6'b010000,
    parameter logic [5:0]  MFLO  = 6'b010010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               accept;
    logic               last_iter;
    logic [2*WIDTH-1:0] prod_step;

    // A new MULTU is only taken when no multiply is running; DONE allows back-to-back.
    assign accept    = in_valid && (Signal == MULTU) && (state_q != MUL);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    // Partial product including the current iteration; used for both prod and the final HI/LO write.
    assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    assign busy  = (state_q == MUL);
    assign done  = (state_q == DONE);
    assign stall = busy && in_valid &&
                   ((Signal == MULTU) || (Signal == MFHI) || (Signal == MFLO));
    assign HiOut = hi_q;
    assign LoOut = lo_q;

    // Next-state and datapath: load on accept, iterate in MUL, commit HI/LO on the last edge.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d  = MUL;
                    mcand_d  = {{WIDTH{1'b0}}, dataA};
                    mplier_d = dataB;
                    prod_d   = '0;
                    cnt_d    = '0;
                end
            end
            MUL: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = DONE;
                    hi_d    = prod_step[2*WIDTH-1:WIDTH];
                    lo_d    = prod_step[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, even mid-multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end
endmodule

// File: tb/tb_hilo_multu_unit.sv
// Directed bench for hilo_multu_unit: latency, results, HI/LO hold, stall, back-to-back, async reset.
module tb_hilo_multu_unit;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_ADD   = 6'b100000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [5:0]  Signal = '0;
    logic [31:0] dataA = '0, dataB = '0;
    logic        busy, done, stall;
    logic [31:0] HiOut, LoOut;

    int total = 0;
    int bad   = 0;

    hilo_multu_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .Signal(Signal),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
        .stall(stall), .HiOut(HiOut), .LoOut(LoOut)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a MULTU for one accept edge, then drop in_valid.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; Signal = OP_MULTU; dataA = a; dataB = b;
        step();
        in_valid = 1'b0;
    endtask

    // Step until done, bounded; reports cycles taken and whether HI/LO held the given values meanwhile.
    task automatic wait_done(input logic [31:0] hh, input logic [31:0] hl,
                             output int n, output bit hold_ok);
        n = 0; hold_ok = 1'b1;
        while (!done && n < 40) begin
            if (HiOut !== hh || LoOut !== hl) hold_ok = 1'b0;
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++; if ({busy, done, stall} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, stall}); end
        total++; if (HiOut !== 32'h0 || LoOut !== 32'h0) begin bad++; $display("FAIL reset_hilo got=%h_%h want=0_0", HiOut, LoOut); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int n; bit hold;
        launch(32'd3, 32'd5);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        wait_done(32'h0, 32'h0, n, hold);
        total++; if (n !== 32) begin bad++; $display("FAIL basic_latency got=%0d want=32", n); end
        total++; if (!hold) begin bad++; $display("FAIL basic_hold got=changed want=held"); end
        total++; if (HiOut !== 32'h0 || LoOut !== 32'hF) begin bad++; $display("FAIL basic_result got=%h_%h want=00000000_0000000f", HiOut, LoOut); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_done_busy got=%b want=0", busy); end
        step();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL basic_idle got=%b want=00", {busy, done}); end
    endtask

    task automatic test_max();
        int n; bit hold;
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(32'h0, 32'hF, n, hold);
        total++; if (!hold) begin bad++; $display("FAIL max_hold got=changed want=held"); end
        total++; if (n !== 32 || HiOut !== 32'hFFFF_FFFE || LoOut !== 32'h1) begin bad++; $display("FAIL max_result got=%0d:%h_%h want=32:fffffffe_00000001", n, HiOut, LoOut); end
        step();
    endtask

    task automatic test_mfhi_stall();
        int n = 0; bit st_ok = 1'b1;
        launch(32'h8000_0000, 32'd4);
        in_valid = 1'b1; Signal = OP_MFHI;
        #1;
        while (busy && n < 40) begin
            if (stall !== 1'b1) st_ok = 1'b0;
            step();
            n++;
        end
        total++; if (!st_ok || n !== 32) begin bad++; $display("FAIL mfhi_stall got=ok%0b/%0d want=ok1/32", st_ok, n); end
        total++; if (done !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL mfhi_done_stall got=done%b stall%b want=done1 stall0", done, stall); end
        total++; if (HiOut !== 32'h2 || LoOut !== 32'h0) begin bad++; $display("FAIL mfhi_new_hi got=%h_%h want=00000002_00000000", HiOut, LoOut); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        int n; bit hold;
        launch(32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) step();
        #2 rst = 1'b1;
        #1;
        total++; if ({busy, done, stall} !== 3'b000 || HiOut !== 32'h0 || LoOut !== 32'h0) begin bad++; $display("FAIL async_reset got=%b %h_%h want=000 0_0", {busy, done, stall}, HiOut, LoOut); end
        step();
        rst = 1'b0;
        step();
        launch(32'h1234_5678, 32'h9ABC_DEF0);
        wait_done(32'h0, 32'h0, n, hold);
        total++; if (n !== 32 || HiOut !== 32'h0B00_EA4E || LoOut !== 32'h242D_2080) begin bad++; $display("FAIL fresh_result got=%0d:%h_%h want=32:0b00ea4e_242d2080", n, HiOut, LoOut); end
        step();
    endtask

    task automatic test_noop();
        bit ok = 1'b1;
        in_valid = 1'b1; Signal = OP_ADD; dataA = 32'd9; dataB = 32'd9;
        repeat (5) begin
            step();
            if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) ok = 1'b0;
        end
        total++; if (!ok || HiOut !== 32'h0B00_EA4E || LoOut !== 32'h242D_2080) begin bad++; $display("FAIL noop_add got=ok%0b %h_%h want=ok1 0b00ea4e_242d2080", ok, HiOut, LoOut); end
        ok = 1'b1;
        in_valid = 1'b0; Signal = OP_MULTU;
        repeat (5) begin
            step();
            if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) ok = 1'b0;
        end
        total++; if (!ok || HiOut !== 32'h0B00_EA4E || LoOut !== 32'h242D_2080) begin bad++; $display("FAIL noop_invalid got=ok%0b %h_%h want=ok1 0b00ea4e_242d2080", ok, HiOut, LoOut); end
    endtask

    task automatic test_back_to_back();
        int n = 0; bit st_ok = 1'b1, hold;
        launch(32'h0001_0000, 32'h0001_0000);
        in_valid = 1'b1; Signal = OP_MULTU; dataA = 32'd7; dataB = 32'd0;
        #1;
        while (busy && n < 40) begin
            if (stall !== 1'b1) st_ok = 1'b0;
            step();
            n++;
        end
        total++; if (!st_ok || n !== 32) begin bad++; $display("FAIL b2b_stall got=ok%0b/%0d want=ok1/32", st_ok, n); end
        total++; if (done !== 1'b1 || stall !== 1'b0 || HiOut !== 32'h1 || LoOut !== 32'h0) begin bad++; $display("FAIL b2b_first got=d%b s%b %h_%h want=d1 s0 00000001_00000000", done, stall, HiOut, LoOut); end
        step();
        in_valid = 1'b0;
        total++; if (busy !== 1'b1 || HiOut !== 32'h1) begin bad++; $display("FAIL b2b_accept got=busy%b hi%h want=busy1 hi00000001", busy, HiOut); end
        wait_done(32'h1, 32'h0, n, hold);
        total++; if (n + 1 !== 33 || !hold) begin bad++; $display("FAIL b2b_spacing got=%0d hold%0b want=33 hold1", n + 1, hold); end
        total++; if (HiOut !== 32'h0 || LoOut !== 32'h0) begin bad++; $display("FAIL b2b_second got=%h_%h want=0_0", HiOut, LoOut); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_mfhi_stall();
        test_async_reset();
        test_noop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
